// File: rtl/mm_pkg.sv
// mm_pkg: definitions shared by the matrix-multiplier sequencer, memory bank
// and MAC datapath.
//   state_t : sequencer FSM states
//   MM_N    : default matrix dimension used across the multiplier
package mm_pkg;

   localparam int MM_N = 3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CLR  = 3'd1,
      MAC  = 3'd2,
      WB   = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/mm_idx_counter.sv
// mm_idx_counter: modulo-N index counter for the sequencer loops.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : advance by one, wrapping N-1 -> 0
//   value      : current index (registered)
//   last       : value == N-1
module mm_idx_counter #(
   parameter int N  = 3,
   parameter int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   output logic [IW-1:0] value,
   output logic          last
);

   // Wrap point is N-1, not 2^IW-1, so non-power-of-two N wraps correctly.
   localparam logic [IW-1:0] MAX_IDX = IW'(N - 1);

   assign last = (value == MAX_IDX);

   // Index register: clear, wrap at N-1, or increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= {IW{1'b0}};
      end else if (clr) begin
         value <= {IW{1'b0}};
      end else if (en) begin
         value <= last ? {IW{1'b0}} : (value + IW'(1));
      end else begin
         value <= value;
      end
   end

endmodule

// File: rtl/mm_sequencer.sv
// mm_sequencer: control sequencer for the N x N matrix multiplier. For each
// output element C[row][col] it clears the accumulator, issues N MAC steps
// over k and writes the result back, then pulses done.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a multiply (sampled only in IDLE)
//   stall               : freeze state and indices, suppress strobes
//   abort               : return to IDLE next edge, no done pulse
//   busy, done          : handshake (busy = not IDLE, done = 1-cycle pulse)
//   row, col, k         : current element / inner-product indices
//   acc_clr, acc_en, wr_en : datapath strobes
module mm_sequencer
   import mm_pkg::*;
#(
   parameter int N  = MM_N,
   parameter int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          stall,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic [IW-1:0] row,
   output logic [IW-1:0] col,
   output logic [IW-1:0] k,
   output logic          acc_clr,
   output logic          acc_en,
   output logic          wr_en
);

   state_t state_r;
   state_t state_nxt_s;
   logic   go_s;
   logic   idx_clr_s;
   logic   k_last_s;
   logic   col_last_s;
   logic   row_last_s;
   logic   row_en_s;

   // A step only takes effect when neither stalled nor aborted.
   assign go_s      = ~stall & ~abort;
   // Indices are held at zero outside an operation and on abort.
   assign idx_clr_s = abort | (state_r == IDLE) | (state_r == DONE);
   assign row_en_s  = wr_en & col_last_s;

   mm_idx_counter #(.N(N), .IW(IW)) u_k_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (idx_clr_s),
      .en    (acc_en),
      .value (k),
      .last  (k_last_s)
   );

   mm_idx_counter #(.N(N), .IW(IW)) u_col_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (idx_clr_s),
      .en    (wr_en),
      .value (col),
      .last  (col_last_s)
   );

   mm_idx_counter #(.N(N), .IW(IW)) u_row_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (idx_clr_s),
      .en    (row_en_s),
      .value (row),
      .last  (row_last_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic and strobe decode; abort overrides every transition.
   always_comb begin
      state_nxt_s = state_r;
      busy        = (state_r != IDLE);
      done        = 1'b0;
      acc_clr     = 1'b0;
      acc_en      = 1'b0;
      wr_en       = 1'b0;
      if (abort && (state_r != IDLE)) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (start && !abort) begin
                  state_nxt_s = CLR;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            CLR: begin
               acc_clr = go_s;
               if (go_s) begin
                  state_nxt_s = MAC;
               end else begin
                  state_nxt_s = CLR;
               end
            end
            MAC: begin
               acc_en = go_s;
               if (go_s && k_last_s) begin
                  state_nxt_s = WB;
               end else begin
                  state_nxt_s = MAC;
               end
            end
            WB: begin
               wr_en = go_s;
               if (!go_s) begin
                  state_nxt_s = WB;
               end else if (row_last_s && col_last_s) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = CLR;
               end
            end
            DONE: begin
               done        = ~abort;
               state_nxt_s = IDLE;
            end
            default: begin
               state_nxt_s = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mm_sequencer.sv
// tb_mm_sequencer: directed self-checking bench for mm_sequencer (N=3 and N=5).
module tb_mm_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start3 = 1'b0, stall3 = 1'b0, abort3 = 1'b0;
   logic       start5 = 1'b0, stall5 = 1'b0, abort5 = 1'b0;
   logic       busy3, done3, acc_clr3, acc_en3, wr_en3;
   logic       busy5, done5, acc_clr5, acc_en5, wr_en5;
   logic [1:0] row3, col3, k3;
   logic [2:0] row5, col5, k5;

   int n_cmp = 0;
   int n_err = 0;
   int c_clr = 0, c_mac = 0, c_wr = 0, c_wr5 = 0;
   int wr_base = 0;

   always #5 clk = ~clk;

   mm_sequencer #(.N(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .stall(stall3), .abort(abort3),
      .busy(busy3), .done(done3), .row(row3), .col(col3), .k(k3),
      .acc_clr(acc_clr3), .acc_en(acc_en3), .wr_en(wr_en3)
   );

   mm_sequencer #(.N(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .start(start5), .stall(stall5), .abort(abort5),
      .busy(busy5), .done(done5), .row(row5), .col(col5), .k(k5),
      .acc_clr(acc_clr5), .acc_en(acc_en5), .wr_en(wr_en5)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Strobe counting and per-cycle checks, sampled on the falling edge.
   always @(negedge clk) begin
      if (acc_clr3) c_clr <= c_clr + 1;
      if (acc_en3)  c_mac <= c_mac + 1;
      if (wr_en3) begin
         c_wr <= c_wr + 1;
         check("wr_order", int'({row3, col3}),
               ((c_wr - wr_base) / 3) * 4 + ((c_wr - wr_base) % 3));
      end
      if (stall3 && rst_n)
         check("stall_strobes", int'(acc_clr3 | acc_en3 | wr_en3), 0);
      if (wr_en5) c_wr5 <= c_wr5 + 1;
      if (busy5)
         check("n5_range", int'((row5 <= 3'd4) && (col5 <= 3'd4) && (k5 <= 3'd4)), 1);
   end

   // Edges after the start edge until done is seen (done follows edge E0+lat).
   task automatic wait_done(input bit sel5, input int limit, output int lat);
      lat = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if ((sel5 ? done5 : done3) == 1'b1) begin
            lat = i;
            break;
         end
         @(posedge clk);
      end
   endtask

   // One N=3 operation, optionally stalled 4 cycles at (1,2) k=1.
   task automatic run3(input string tag, input int exp_lat, input bit do_stall);
      int b_clr, b_mac, b_wr, lat;
      b_clr = c_clr; b_mac = c_mac; b_wr = c_wr;
      wr_base = c_wr;
      start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      check({tag, "_busy_on"}, int'(busy3), 1);
      fork
         wait_done(1'b0, 300, lat);
         if (do_stall) begin
            bit found;
            int hold;
            found = 1'b0;
            for (int i = 0; i < 100; i++) begin
               if (acc_en3 && row3 == 2'd1 && col3 == 2'd2 && k3 == 2'd1) begin
                  found = 1'b1;
                  break;
               end
               @(posedge clk); #1;
            end
            check({tag, "_stall_hit"}, int'(found), 1);
            hold = int'({row3, col3, k3});
            stall3 = 1'b1;
            repeat (4) begin
               @(negedge clk);
               check({tag, "_stall_hold"}, int'({row3, col3, k3}), hold);
            end
            @(posedge clk); #1 stall3 = 1'b0;
         end
      join
      check({tag, "_lat"}, lat, exp_lat);
      @(posedge clk); #1;
      check({tag, "_busy_off"}, int'(busy3), 0);
      check({tag, "_n_clr"}, c_clr - b_clr, 9);
      check({tag, "_n_mac"}, c_mac - b_mac, 27);
      check({tag, "_n_wr"}, c_wr - b_wr, 9);
   endtask

   initial begin
      int lat, b_clr, b_mac, b_wr, b_wr5;
      bit found;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_outputs", int'({busy3, done3, acc_clr3, acc_en3, wr_en3, row3, col3, k3}), 0);
      rst_n = 1'b1;

      // Plain run and stalled run
      run3("plain", 45, 1'b0);
      run3("stall", 49, 1'b1);

      // N=5: 25 writes, done follows E0+175
      b_wr5 = c_wr5;
      start5 = 1'b1;
      @(posedge clk); #1 start5 = 1'b0;
      wait_done(1'b1, 400, lat);
      check("n5_lat", lat, 175);
      @(posedge clk); #1;
      check("n5_busy_off", int'(busy5), 0);
      check("n5_n_wr", c_wr5 - b_wr5, 25);

      // Abort in WB at (1,1)
      wr_base = c_wr;
      start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (wr_en3 && row3 == 2'd1 && col3 == 2'd1) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("abort_hit", int'(found), 1);
      abort3 = 1'b1;
      @(posedge clk); #1 abort3 = 1'b0;
      check("abort_busy", int'(busy3), 0);
      check("abort_idx", int'(row3) + int'(col3) + int'(k3), 0);
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", int'(done3 | busy3), 0);
      end
      run3("after_abort", 45, 1'b0);

      // start held high: back-to-back operations
      b_clr = c_clr; b_mac = c_mac; b_wr = c_wr;
      wr_base = c_wr;
      start3 = 1'b1;
      @(posedge clk); #1;
      wait_done(1'b0, 300, lat);
      check("held1_lat", lat, 45);
      check("held1_n_clr", c_clr - b_clr, 9);
      check("held1_n_mac", c_mac - b_mac, 27);
      b_clr = c_clr; b_mac = c_mac; b_wr = c_wr;
      wr_base = c_wr;
      @(posedge clk);
      @(negedge clk);
      check("held_idle_gap", int'(busy3), 0);
      @(posedge clk); #1 start3 = 1'b0;
      check("held2_clr", int'(acc_clr3), 1);
      wait_done(1'b0, 300, lat);
      check("held2_lat", lat, 45);
      @(posedge clk); #1;
      check("held2_n_clr", c_clr - b_clr, 9);
      check("held2_n_mac", c_mac - b_mac, 27);
      check("held2_n_wr", c_wr - b_wr, 9);

      // Asynchronous reset mid-MAC
      start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (acc_en3 && k3 == 2'd1) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("rst_hit", int'(found), 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst", int'({busy3, done3, acc_clr3, acc_en3, wr_en3, row3, col3, k3}), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("post_rst_idle", int'(busy3 | done3 | acc_clr3), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
